prefetcher: RTL and testbench

Stride/next-line hardware prefetcher attached to the cache controller. It observes every tag-check access (address plus hit/miss) and trains a single-stream stride detector. On a miss, or on a confidently detected stride, it generates PREFETCH_DEGREE line-aligned prefetch addresses into a small issue FIFO. The FIFO is drained over a valid/ready handshake.

---
 rtl/prefetcher.sv | 152 +++++++++++++++
 tb/tb_prefetcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetcher.sv
// Stride/next-line prefetcher: trains on tag-check accesses and queues line-aligned prefetch addresses.
// Optional stride training is compiled in with `define PREFETCH_STRIDE_EN; without it this is a pure next-line prefetcher.
module prefetcher #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_BYTES      = 64,
  parameter int PREFETCH_DEGREE = 2,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] access_addr,
  input  logic                  access_valid,
  input  logic                  cache_miss,
  output logic [ADDR_WIDTH-1:0] prefetch_addr,
  output logic                  prefetch_valid,
  input  logic                  prefetch_ready
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(LINE_STEP - 1'b1);
  localparam logic [3:0] DEGREE = 4'(PREFETCH_DEGREE);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] line;
  logic [1:0]            conf_new;
  logic [ADDR_WIDTH-1:0] stride_sel;
  logic                  trigger;

  assign line = access_addr & LINE_MASK;

`ifdef PREFETCH_STRIDE_EN
  logic [ADDR_WIDTH-1:0] last_line;
  logic [ADDR_WIDTH-1:0] last_stride;
  logic [ADDR_WIDTH-1:0] stride_new;
  logic [ADDR_WIDTH-1:0] delta;
  logic [1:0]            conf;
  logic                  has_hist;

  assign delta = line - last_line;

  // The first access after reset only seeds history, so confidence cannot move on it.
  always_comb begin
    conf_new   = conf;
    stride_new = last_stride;
    if (access_valid && has_hist) begin
      if (delta == last_stride && delta != '0) begin
        conf_new = (conf == 2'd3) ? 2'd3 : conf + 2'd1;
      end else begin
        conf_new   = 2'd0;
        stride_new = delta;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_line   <= '0;
      last_stride <= '0;
      conf        <= 2'd0;
      has_hist    <= 1'b0;
    end else if (access_valid) begin
      last_line   <= line;
      last_stride <= stride_new;
      conf        <= conf_new;
      has_hist    <= 1'b1;
    end
  end

  assign stride_sel = (conf_new >= 2'd2) ? stride_new : LINE_STEP;
`else
  assign conf_new   = 2'd0;
  assign stride_sel = LINE_STEP;
`endif

  assign trigger = access_valid && (cache_miss || conf_new >= 2'd2);

  // Generator: a trigger reloads it and suppresses the push for that cycle.
  logic [ADDR_WIDTH-1:0] gen_base;
  logic [ADDR_WIDTH-1:0] gen_step;
  logic [ADDR_WIDTH-1:0] cand;
  logic [ADDR_WIDTH-1:0] last_push;
  logic [3:0]            gen_cnt;
  logic                  has_push;
  logic                  gen_go;
  logic                  push;
  logic                  pop;
  logic                  full;

  assign cand   = gen_base + gen_step;
  assign gen_go = !trigger && gen_cnt != 4'd0 && !full;
  assign push   = gen_go && !(has_push && cand == last_push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_base  <= '0;
      gen_step  <= '0;
      gen_cnt   <= 4'd0;
      last_push <= '0;
      has_push  <= 1'b0;
    end else if (trigger) begin
      gen_base <= line;
      gen_step <= stride_sel;
      gen_cnt  <= DEGREE;
    end else if (gen_go) begin
      gen_base <= cand;
      gen_cnt  <= gen_cnt - 4'd1;
      if (push) begin
        last_push <= cand;
        has_push  <= 1'b1;
      end
    end
  end

  // Issue FIFO. Handshake: the head transfers on any edge where prefetch_valid && prefetch_ready;
  // prefetch_valid never drops and prefetch_addr never changes while waiting for ready.
  logic [ADDR_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [ADDR_WIDTH-1:0] last_out;

  assign full           = (count == DEPTH);
  assign prefetch_valid = (count != '0);
  assign pop            = prefetch_valid && prefetch_ready;
  assign prefetch_addr  = prefetch_valid ? mem[rd_ptr] : last_out;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_out <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetcher.sv
// Bench for prefetcher: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_prefetcher;

  localparam int AW    = 32;
  localparam int LINE  = 64;
  localparam int DEG   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] access_addr = '0;
  logic          access_valid = 1'b0;
  logic          cache_miss = 1'b0;
  logic [AW-1:0] prefetch_addr;
  logic          prefetch_valid;
  logic          prefetch_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  prefetcher #(.ADDR_WIDTH(AW), .LINE_BYTES(LINE), .PREFETCH_DEGREE(DEG), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .access_addr(access_addr), .access_valid(access_valid),
    .cache_miss(cache_miss), .prefetch_addr(prefetch_addr), .prefetch_valid(prefetch_valid),
    .prefetch_ready(prefetch_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending candidates as a list, FIFO as an occupancy count plus expected queue.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] pend_q[$];
  int            m_cnt = 0;
  bit            m_hist = 0;
  logic [AW-1:0] m_last_line = '0;
  logic [AW-1:0] m_stride = '0;
  int            m_conf = 0;
  bit            m_has_last = 0;
  logic [AW-1:0] m_last = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      m_cnt = 0; m_hist = 0; m_last_line = '0; m_stride = '0; m_conf = 0; m_has_last = 0;
    end else begin
      logic [AW-1:0] line, step, cand, delta;
      bit trig, do_pop, full;
      int conf_new;
      do_pop = prefetch_ready && (m_cnt > 0);
      full = (m_cnt == DEPTH);
      trig = 0;
      step = LINE;
      line = access_addr & ~(AW'(LINE - 1));
      if (access_valid) begin
        conf_new = 0;
`ifdef PREFETCH_STRIDE_EN
        if (!m_hist) begin
          conf_new = m_conf;
        end else begin
          delta = line - m_last_line;
          if (delta == m_stride && delta != 0) m_conf = (m_conf < 3) ? m_conf + 1 : 3;
          else begin
            m_stride = delta;
            m_conf = 0;
          end
          conf_new = m_conf;
        end
        m_hist = 1;
        m_last_line = line;
        if (conf_new >= 2) step = m_stride;
`endif
        trig = cache_miss || (conf_new >= 2);
      end
      if (trig) begin
        pend_q.delete();
        for (int i = 1; i <= DEG; i++) pend_q.push_back(line + AW'(i) * step);
      end else if (pend_q.size() > 0 && !full) begin
        cand = pend_q.pop_front();
        if (!(m_has_last && cand == m_last)) begin
          exp_q.push_back(cand);
          m_cnt++;
          m_last = cand;
          m_has_last = 1;
        end
      end
      if (do_pop) m_cnt--;
    end
  end

  // Monitor: compares the FIFO head to the oldest expected address; a handshake retires it.
  always @(negedge clk) begin
    check("valid", AW'(prefetch_valid), AW'(m_cnt != 0));
    if (prefetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_prefetch actual=%h required=none t=%0t", prefetch_addr, $time);
      end else begin
        check("head_addr", prefetch_addr, exp_q[0]);
        if (prefetch_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_access(input logic v, input logic m, input logic [AW-1:0] a);
    access_valid = v;
    cache_miss = m;
    access_addr = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_access(1'b1, 1'b1, AW'($urandom));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", AW'(prefetch_valid), '0);
      check("rst_addr", prefetch_addr, '0);
    end
    rst_n = 1'b1;
    set_access(1'b0, 1'b0, '0);
  endtask

  logic [AW-1:0] run_addr, run_stride;
  int run_left;

  initial begin
    do_reset();
    tick();
    check("post_rst_valid", AW'(prefetch_valid), '0);

    // Next-line on a miss with the consumer always ready.
    prefetch_ready = 1'b1;
    set_access(1'b1, 1'b1, 32'h0000_1000);
    tick();
    set_access(1'b0, 1'b0, '0);
    check("miss_lat_valid", AW'(prefetch_valid), '0);
    tick();
    check("miss_first_valid", AW'(prefetch_valid), 32'd1);
    check("miss_first", prefetch_addr, 32'h0000_1040);
    tick();
    check("miss_second", prefetch_addr, 32'h0000_1080);
    tick();
    check("miss_done", AW'(prefetch_valid), '0);

    // A lone hit trains nothing and prefetches nothing.
    do_reset();
    set_access(1'b1, 1'b0, 32'h0000_2000);
    tick();
    set_access(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    check("hit_quiet", AW'(prefetch_valid), '0);

    // Constant-stride hits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_access(1'b1, 1'b0, AW'(i * 32'h100));
      tick();
    end
    set_access(1'b0, 1'b0, '0);
    tick();
`ifdef PREFETCH_STRIDE_EN
    check("stride_first", prefetch_addr, 32'h0000_0400);
    tick();
    check("stride_second", prefetch_addr, 32'h0000_0500);
`else
    check("nextline_quiet0", AW'(prefetch_valid), '0);
    tick();
    check("nextline_quiet1", AW'(prefetch_valid), '0);
`endif

    // Backpressure: fill the FIFO, hold the head, then drain in order.
    do_reset();
    prefetch_ready = 1'b0;
    set_access(1'b1, 1'b1, 32'h0000_1000);
    tick();
    set_access(1'b0, 1'b0, '0);
    tick();
    tick();
    set_access(1'b1, 1'b1, 32'h0000_3000);
    tick();
    set_access(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_head_stable", prefetch_addr, 32'h0000_1040);
    end
    prefetch_ready = 1'b1;
    tick();
    check("bp_drain1", prefetch_addr, 32'h0000_1080);
    tick();
    check("bp_drain2", prefetch_addr, 32'h0000_3040);
    tick();
    check("bp_drain3", prefetch_addr, 32'h0000_3080);
    tick();
    check("bp_empty", AW'(prefetch_valid), '0);

    // Address wrap-around.
    do_reset();
    set_access(1'b1, 1'b1, 32'hFFFF_FFC0);
    tick();
    set_access(1'b0, 1'b0, '0);
    tick();
    check("wrap_valid", AW'(prefetch_valid), 32'd1);
    check("wrap_first", prefetch_addr, 32'h0000_0000);
    tick();
    check("wrap_second", prefetch_addr, 32'h0000_0040);

    // Randomized traffic: strided runs, random misses, random backpressure, rare resets.
    do_reset();
    run_left = 0;
    run_addr = '0;
    run_stride = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if (run_left == 0) begin
        run_left = $urandom_range(3, 8);
        run_addr = AW'($urandom_range(0, 63)) << 6;
        run_stride = AW'($urandom_range(0, 4)) << 6;
        if ($urandom_range(0, 3) == 0) run_stride = -run_stride;
        if ($urandom_range(0, 9) == 0) run_addr = 32'hFFFF_FF00;
      end
      if ($urandom_range(0, 3) != 0) begin
        set_access(1'b1, $urandom_range(0, 3) == 0, run_addr | AW'($urandom_range(0, 63)));
        run_addr = run_addr + run_stride;
        run_left--;
      end else begin
        set_access(1'b0, 1'($urandom_range(0, 1)), AW'($urandom));
      end
      prefetch_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    set_access(1'b0, 1'b0, '0);
    prefetch_ready = 1'b1;
    for (int i = 0; i < 64 && (exp_q.size() != 0 || prefetch_valid); i++) tick();
    tick();
    check("drain_queue", AW'(exp_q.size()), '0);
    check("drain_valid", AW'(prefetch_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
